// File: rtl/exe_mul_seq_pkg.sv
// exe_mul_seq_pkg: shared CPU definitions (multiply ALU codes, multiplier FSM states)
package exe_mul_seq_pkg;
  localparam logic [4:0] ALU_MUL    = 5'd10;
  localparam logic [4:0] ALU_MULH   = 5'd11;
  localparam logic [4:0] ALU_MULHSU = 5'd12;
  localparam logic [4:0] ALU_MULHU  = 5'd13;
  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;
endpackage

// File: rtl/exe_mul_seq.sv
// exe_mul_seq: sign-magnitude radix-2 shift-add multiplier; in: clk rst start ALU_ctrl rs1_data rs2_data flush; out: stall done mul_result
module exe_mul_seq
  import exe_mul_seq_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int CNT_W  = $clog2(DATA_W) + 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [4:0]        ALU_ctrl,
  input  logic [DATA_W-1:0] rs1_data,
  input  logic [DATA_W-1:0] rs2_data,
  input  logic              flush,
  output logic              stall,
  output logic              done,
  output logic [DATA_W-1:0] mul_result
);
  state_t              r_state;
  logic [CNT_W-1:0]    r_cnt;
  logic [2*DATA_W-1:0] r_acc;
  logic [2*DATA_W-1:0] r_mcand;
  logic [DATA_W:0]     r_b;
  logic                r_sign;
  logic                r_hi;
  logic                w_is_mul;
  logic                w_accept;
  logic                w_a_neg;
  logic                w_b_neg;
  logic [DATA_W:0]     w_a_ext;
  logic [DATA_W:0]     w_b_ext;
  logic [DATA_W:0]     w_a_mag;
  logic [DATA_W:0]     w_b_mag;
  logic [2*DATA_W-1:0] w_acc_nxt;
  logic [2*DATA_W-1:0] w_prod;
  logic                w_last;
  assign w_is_mul  = ALU_ctrl inside {ALU_MUL, ALU_MULH, ALU_MULHSU, ALU_MULHU};
  assign w_accept  = (r_state == IDLE) & start & w_is_mul & ~flush;
  assign stall     = ~rst & (w_accept | (r_state == CALC));
  assign w_a_neg   = rs1_data[DATA_W-1] & (ALU_ctrl != ALU_MULHU);
  assign w_b_neg   = rs2_data[DATA_W-1] & ((ALU_ctrl == ALU_MUL) | (ALU_ctrl == ALU_MULH));
  assign w_a_ext   = {w_a_neg, rs1_data};
  assign w_b_ext   = {w_b_neg, rs2_data};
  assign w_a_mag   = w_a_neg ? -w_a_ext : w_a_ext;
  assign w_b_mag   = w_b_neg ? -w_b_ext : w_b_ext;
  assign w_acc_nxt = r_acc + (r_b[0] ? r_mcand : '0);
  assign w_prod    = r_sign ? -w_acc_nxt : w_acc_nxt;
  assign w_last    = r_cnt == CNT_W'(DATA_W - 1);
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= IDLE;
      r_cnt      <= '0;
      r_acc      <= '0;
      r_mcand    <= '0;
      r_b        <= '0;
      r_sign     <= 1'b0;
      r_hi       <= 1'b0;
      mul_result <= '0;
      done       <= 1'b0;
    end else if (flush) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      done    <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          done <= 1'b0;
          if (w_accept) begin
            r_state <= CALC;
            r_cnt   <= '0;
            r_acc   <= '0;
            r_mcand <= {{(DATA_W-1){1'b0}}, w_a_mag};
            r_b     <= w_b_mag;
            r_sign  <= w_a_neg ^ w_b_neg;
            r_hi    <= ALU_ctrl != ALU_MUL;
          end
        end
        CALC: begin
          r_acc   <= w_acc_nxt;
          r_mcand <= r_mcand << 1;
          r_b     <= r_b >> 1;
          r_cnt   <= r_cnt + CNT_W'(1);
          if (w_last) begin
            r_state    <= DONE;
            done       <= 1'b1;
            mul_result <= r_hi ? w_prod[2*DATA_W-1:DATA_W] : w_prod[DATA_W-1:0];
          end
        end
        default: begin
          r_state <= IDLE;
          done    <= 1'b0;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_exe_mul_seq.sv
// tb_exe_mul_seq: scoreboard bench for exe_mul_seq
module tb_exe_mul_seq;
  import exe_mul_seq_pkg::*;
  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [4:0]  ALU_ctrl;
  logic [31:0] rs1_data;
  logic [31:0] rs2_data;
  logic        flush;
  logic        stall;
  logic        done;
  logic [31:0] mul_result;
  int          n_chk = 0;
  int          n_err = 0;
  logic [31:0] sb_q[$];
  always #5 clk = ~clk;
  exe_mul_seq dut (
    .clk(clk), .rst(rst), .start(start), .ALU_ctrl(ALU_ctrl),
    .rs1_data(rs1_data), .rs2_data(rs2_data), .flush(flush),
    .stall(stall), .done(done), .mul_result(mul_result)
  );
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask
  function automatic logic [31:0] model(input logic [4:0] c, input logic [31:0] a, input logic [31:0] b);
    logic signed [65:0] sa, sb, p;
    sa = (c == ALU_MULHU) ? {34'b0, a} : {{34{a[31]}}, a};
    sb = (c == ALU_MUL || c == ALU_MULH) ? {{34{b[31]}}, b} : {34'b0, b};
    p  = sa * sb;
    return (c == ALU_MUL) ? p[31:0] : p[63:32];
  endfunction
  always @(negedge clk) begin
    if (done) begin
      if (sb_q.size() == 0) check("unexpected_done", 32'(done), 32'd0);
      else check("result", mul_result, sb_q.pop_front());
    end
  end
  task automatic run_op(input logic [4:0] c, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] exp, input bit now);
    int n;
    int bad;
    if (!now) begin
      @(posedge clk);
      #1;
    end
    start = 1'b1; ALU_ctrl = c; rs1_data = a; rs2_data = b;
    sb_q.push_back(exp);
    #1 check("stall_accept", 32'(stall), 32'd1);
    @(posedge clk);
    #1 start = 1'b0;
    n = 1;
    bad = 0;
    while (!done && n < 100) begin
      if (!stall) bad++;
      @(posedge clk);
      #1;
      n++;
    end
    check("done_cycle", n, 32'd33);
    check("stall_calc_low", bad, 32'd0);
    check("stall_in_done", 32'(stall), 32'd0);
  endtask
  initial begin
    logic [31:0] prev;
    logic [31:0] ra, rb;
    logic [4:0]  rc;
    int          cnt;
    rst = 1'b1; start = 1'b0; flush = 1'b0; ALU_ctrl = '0; rs1_data = '0; rs2_data = '0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_stall", 32'(stall), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_result", mul_result, 32'd0);
    rst = 1'b0;
    run_op(ALU_MUL, 32'd7, 32'hFFFF_FFFD, 32'hFFFF_FFEB, 1'b0);
    run_op(ALU_MUL, 32'd0, 32'h1234_5678, 32'd0, 1'b0);
    run_op(ALU_MULH, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 1'b0);
    run_op(ALU_MULHU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 1'b0);
    run_op(ALU_MUL, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1'b0);
    run_op(ALU_MULH, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 1'b0);
    run_op(ALU_MULHSU, 32'h8000_0000, 32'd2, 32'hFFFF_FFFF, 1'b0);
    for (int i = 0; i < 4; i++) begin
      rc = 5'(ALU_MUL + 5'($urandom_range(0, 3)));
      ra = $urandom;
      rb = $urandom;
      run_op(rc, ra, rb, model(rc, ra, rb), 1'b0);
    end
    run_op(ALU_MULHSU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
    prev = mul_result;
    @(posedge clk);
    #1 start = 1'b1; ALU_ctrl = ALU_MUL; rs1_data = 32'd3; rs2_data = 32'd5;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (9) @(posedge clk);
    #1 flush = 1'b1;
    @(posedge clk);
    #1 flush = 1'b0;
    check("flush_idle_stall", 32'(stall), 32'd0);
    check("flush_no_done", 32'(done), 32'd0);
    check("flush_result_kept", mul_result, prev);
    run_op(ALU_MULH, 32'h7FFF_FFFF, 32'h7FFF_FFFF, 32'h3FFF_FFFF, 1'b1);
    @(posedge clk);
    #1 start = 1'b1; ALU_ctrl = 5'd0; rs1_data = 32'd9; rs2_data = 32'd9;
    #1 check("add_stall", 32'(stall), 32'd0);
    cnt = 0;
    repeat (40) begin
      @(posedge clk);
      #1 if (done) cnt++;
    end
    start = 1'b0;
    check("add_no_done", cnt, 32'd0);
    @(posedge clk);
    #1 start = 1'b1; ALU_ctrl = ALU_MUL; rs1_data = 32'd11; rs2_data = 32'd13;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (4) @(posedge clk);
    #1 rst = 1'b1;
    #1;
    check("midrst_stall", 32'(stall), 32'd0);
    check("midrst_done", 32'(done), 32'd0);
    check("midrst_result", mul_result, 32'd0);
    @(posedge clk);
    #1 rst = 1'b0;
    #1 check("postrst_idle", 32'(stall), 32'd0);
    run_op(ALU_MUL, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd1, 1'b0);
    repeat (3) @(posedge clk);
    check("sb_drain", sb_q.size(), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule
